pitch_shift_core: RTL and testbench



---
 rtl/pitch_shift_pkg.sv | 23 ++
 rtl/pitch_interp.sv | 39 +++
 rtl/pitch_shift_core.sv | 213 +++++++++++++++++++++
 tb/tb_pitch_shift_core.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pitch_shift_pkg.sv
// Shared definitions for the pitch shifter.
//   FRAC_W_DEF  : default number of fractional bits in ratio/phase
//   UNITY_RATIO : ratio code for 1.0 at the default FRAC_W
//   stage_e     : read/interpolate pipeline stage
//   chan_lsb()  : LSB position of a channel inside a packed sample word
package pitch_shift_pkg;

  localparam int FRAC_W_DEF  = 8;
  localparam int UNITY_RATIO = 1 << FRAC_W_DEF;

  typedef enum logic [1:0] {
    IDLE,  // waiting for an input sample
    RD0,   // s0 present on the read register
    RD1,   // s1 present on the read register, result computed
    OUT    // result presented with out_valid
  } stage_e;

  // Channel ch occupies bits [chan_lsb(ch, dw) +: dw]; channel 0 is in the LSBs.
  function automatic int chan_lsb(input int ch, input int dw);
    return ch * dw;
  endfunction

endpackage

// File: rtl/pitch_interp.sv
// Single-channel linear interpolator (purely combinational).
//   s0, s1 : signed neighbouring samples
//   frac   : unsigned fractional position between s0 and s1
//   y      : s0 + (((s1 - s0) * frac) >>> FRAC_W), truncated toward -inf
module pitch_interp #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_W     = 8
) (
  input  logic signed [DATA_WIDTH-1:0] s0,
  input  logic signed [DATA_WIDTH-1:0] s1,
  input  logic        [FRAC_W-1:0]     frac,
  output logic signed [DATA_WIDTH-1:0] y
);

  // One guard bit above the exact product width keeps every operand the
  // same width so the multiply is plain modular arithmetic.
  localparam int PW = DATA_WIDTH + FRAC_W + 2;

  logic signed [DATA_WIDTH:0] diff;
  logic signed [PW-1:0]       diff_x;
  logic signed [PW-1:0]       frac_x;
  logic signed [PW-1:0]       prod;
  logic signed [PW-1:0]       step;
  logic signed [PW-1:0]       sum;
  logic                       unused_sum_hi;

  assign diff   = {s1[DATA_WIDTH-1], s1} - {s0[DATA_WIDTH-1], s0};
  assign diff_x = {{(PW-DATA_WIDTH-1){diff[DATA_WIDTH]}}, diff};
  assign frac_x = {{(PW-FRAC_W){1'b0}}, frac};
  assign prod   = diff_x * frac_x;
  assign step   = prod >>> FRAC_W;
  assign sum    = {{(PW-DATA_WIDTH){s0[DATA_WIDTH-1]}}, s0} + step;

  // The result always lies between s0 and s1, so the upper bits are pure
  // sign extension and can be dropped.
  assign y             = sum[DATA_WIDTH-1:0];
  assign unused_sum_hi = ^sum[PW-1:DATA_WIDTH];

endmodule

// File: rtl/pitch_shift_core.sv
// Frame-based multi-channel pitch shifter.
// Input samples fill one bank of a ping-pong frame buffer while the other
// (previously completed) bank is read back by a fractional phase
// accumulator with linear interpolation. One output per input, 3 clk later.
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : one input sample strobe; in_data packed channels (ch0 LSBs)
//   ratio       : resample step, FRAC_W fractional bits, sampled at bank swap
//   bypass      : pass in_data through with the same latency
//   out_valid   : one-cycle strobe per processed sample; out_data result
//   frame_start : one-cycle pulse after each bank swap
//   overrun     : sticky, an in_valid arrived while the pipeline was busy
module pitch_shift_core
  import pitch_shift_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 2,
  parameter int FRAME_LOG2 = 10,
  parameter int FRAC_W     = FRAC_W_DEF,
  parameter int RATIO_W    = FRAC_W + 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic [RATIO_W-1:0]             ratio,
  input  logic                           bypass,
  output logic                           out_valid,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                           frame_start,
  output logic                           overrun
);

  localparam int WORD_W  = CHANNELS * DATA_WIDTH;
  localparam int N       = 1 << FRAME_LOG2;
  localparam int PHASE_W = FRAC_W + FRAME_LOG2;
  localparam logic [RATIO_W-1:0] UNITY = RATIO_W'(1 << FRAC_W);

  // Both banks live in one array addressed by {bank, index}.
  logic [WORD_W-1:0] mem [0:2*N-1];
  logic [WORD_W-1:0] rd_word_q;
  logic              rd_en;
  logic [FRAME_LOG2:0] rd_addr;

  stage_e              stage_q,       stage_d;
  logic [FRAME_LOG2-1:0] wr_ptr_q,    wr_ptr_d;
  logic                wr_bank_q,     wr_bank_d;
  logic [PHASE_W-1:0]  phase_q,       phase_d;
  logic [RATIO_W-1:0]  ratio_q,       ratio_d;
  logic                primed_q,      primed_d;
  logic                frame_start_q, frame_start_d;
  logic                overrun_q,     overrun_d;
  logic                rd_bank_q,     rd_bank_d;
  logic [FRAME_LOG2-1:0] idx_q,       idx_d;
  logic [FRAC_W-1:0]   frac_q,        frac_d;
  logic                rd_primed_q,   rd_primed_d;
  logic                byp_q,         byp_d;
  logic [WORD_W-1:0]   byp_word_q,    byp_word_d;
  logic [WORD_W-1:0]   s0_q,          s0_d;
  logic [WORD_W-1:0]   out_data_q,    out_data_d;
  logic [WORD_W-1:0]   lerp_word;

  logic launch;
  logic swap;

  // Frame buffer: write port for the filling bank, registered read port
  // for the bank being played back. The two banks always differ except when
  // an overrun sample lands right after a swap; the read then sees the old
  // contents.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem[{wr_bank_q, wr_ptr_q}] <= in_data;
    end
    if (rd_en) begin
      rd_word_q <= mem[rd_addr];
    end
  end

  always_comb begin
    stage_d       = stage_q;
    wr_ptr_d      = wr_ptr_q;
    wr_bank_d     = wr_bank_q;
    phase_d       = phase_q;
    ratio_d       = ratio_q;
    primed_d      = primed_q;
    frame_start_d = 1'b0;
    overrun_d     = overrun_q;
    rd_bank_d     = rd_bank_q;
    idx_d         = idx_q;
    frac_d        = frac_q;
    rd_primed_d   = rd_primed_q;
    byp_d         = byp_q;
    byp_word_d    = byp_word_q;
    s0_d          = s0_q;
    out_data_d    = out_data_q;
    rd_en         = 1'b0;
    rd_addr       = '0;

    launch = in_valid && (stage_q == IDLE);
    swap   = in_valid && (&wr_ptr_q);

    case (stage_q)
      IDLE:    if (in_valid) stage_d = RD0;
      RD0:     stage_d = RD1;
      RD1:     stage_d = OUT;
      OUT:     stage_d = IDLE;
      default: stage_d = IDLE;
    endcase

    if (in_valid) begin
      wr_ptr_d = wr_ptr_q + FRAME_LOG2'(1);
      if (stage_q != IDLE) begin
        overrun_d = 1'b1;
      end
    end

    // The read launched on an in_valid edge uses the bank and phase as they
    // were before any swap happening on that same edge.
    if (launch) begin
      rd_en       = 1'b1;
      rd_addr     = {~wr_bank_q, phase_q[PHASE_W-1:FRAC_W]};
      rd_bank_d   = ~wr_bank_q;
      idx_d       = phase_q[PHASE_W-1:FRAC_W];
      frac_d      = phase_q[FRAC_W-1:0];
      rd_primed_d = primed_q;
      byp_d       = bypass;
      byp_word_d  = in_data;
      phase_d     = phase_q + PHASE_W'(ratio_q);
    end

    if (swap) begin
      wr_bank_d     = ~wr_bank_q;
      phase_d       = '0;
      ratio_d       = ratio;
      primed_d      = 1'b1;
      frame_start_d = 1'b1;
    end

    if (stage_q == RD0) begin
      // Neighbour index wraps within the same bank.
      rd_en   = 1'b1;
      rd_addr = {rd_bank_q, idx_q + FRAME_LOG2'(1)};
      s0_d    = rd_word_q;
    end

    if (stage_q == RD1) begin
      if (byp_q) begin
        out_data_d = byp_word_q;
      end else if (rd_primed_q) begin
        out_data_d = lerp_word;
      end else begin
        out_data_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q       <= IDLE;
      wr_ptr_q      <= '0;
      wr_bank_q     <= 1'b0;
      phase_q       <= '0;
      ratio_q       <= UNITY;
      primed_q      <= 1'b0;
      frame_start_q <= 1'b0;
      overrun_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      idx_q         <= '0;
      frac_q        <= '0;
      rd_primed_q   <= 1'b0;
      byp_q         <= 1'b0;
      byp_word_q    <= '0;
      s0_q          <= '0;
      out_data_q    <= '0;
    end else begin
      stage_q       <= stage_d;
      wr_ptr_q      <= wr_ptr_d;
      wr_bank_q     <= wr_bank_d;
      phase_q       <= phase_d;
      ratio_q       <= ratio_d;
      primed_q      <= primed_d;
      frame_start_q <= frame_start_d;
      overrun_q     <= overrun_d;
      rd_bank_q     <= rd_bank_d;
      idx_q         <= idx_d;
      frac_q        <= frac_d;
      rd_primed_q   <= rd_primed_d;
      byp_q         <= byp_d;
      byp_word_q    <= byp_word_d;
      s0_q          <= s0_d;
      out_data_q    <= out_data_d;
    end
  end

  // During RD1 the read register holds s1 and s0_q holds s0.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    localparam int LSB = chan_lsb(gi, DATA_WIDTH);
    pitch_interp #(
      .DATA_WIDTH(DATA_WIDTH),
      .FRAC_W    (FRAC_W)
    ) u_interp (
      .s0  (s0_q[LSB +: DATA_WIDTH]),
      .s1  (rd_word_q[LSB +: DATA_WIDTH]),
      .frac(frac_q),
      .y   (lerp_word[LSB +: DATA_WIDTH])
    );
  end

  assign out_valid   = (stage_q == OUT);
  assign out_data    = out_data_q;
  assign frame_start = frame_start_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_pitch_shift_core.sv
// Bench for pitch_shift_core with N=16 frames, 2 channels, FRAC_W=8.
module tb_pitch_shift_core;
  localparam int DW = 16;
  localparam int CH = 2;
  localparam int FL2 = 4;
  localparam int FW = 8;
  localparam int RW = 10;
  localparam int N = 16;
  localparam int WW = CH * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [WW-1:0] in_data;
  logic [RW-1:0] ratio;
  logic          bypass;
  logic          out_valid;
  logic [WW-1:0] out_data;
  logic          frame_start;
  logic          overrun;

  pitch_shift_core #(
    .DATA_WIDTH(DW), .CHANNELS(CH), .FRAME_LOG2(FL2), .FRAC_W(FW), .RATIO_W(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .ratio(ratio), .bypass(bypass), .out_valid(out_valid), .out_data(out_data),
    .frame_start(frame_start), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  int fs_count = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int chv(input logic [WW-1:0] w, input int c);
    logic signed [DW-1:0] s;
    s = w[c*DW +: DW];
    return int'(s);
  endfunction

  function automatic logic [WW-1:0] mk(input int a, input int b);
    logic [WW-1:0] r;
    r = {b[15:0], a[15:0]};
    return r;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    logic [WW-1:0] word;
  } exp_t;

  exp_t          exp_q[$];
  int            fs_q[$];
  logic [WW-1:0] dut_log[$];
  logic [WW-1:0] cur_f[N];
  logic [WW-1:0] prev_f[N];
  int            m_wptr, m_phase, m_ratio, m_primed, last_launch;

  task automatic model_reset();
    m_wptr = 0; m_phase = 0; m_ratio = 256; m_primed = 0; last_launch = -100;
    exp_q.delete(); fs_q.delete();
  endtask

  // Output k of a frame reads the previous frame at position k*ratio/256,
  // i.e. the running phase sum of launched samples since the last swap.
  task automatic model_step(input int c, input logic [WW-1:0] d, input logic byp, input int rt);
    logic [WW-1:0] e;
    int idx, fr, s0, s1, y;
    if (c - last_launch >= 4) begin
      e = '0;
      if (byp) e = d;
      else if (m_primed != 0) begin
        idx = m_phase / 256;
        fr  = m_phase % 256;
        for (int k = 0; k < CH; k++) begin
          s0 = chv(prev_f[idx], k);
          s1 = chv(prev_f[(idx + 1) % N], k);
          y  = s0 + (((s1 - s0) * fr) >>> 8);
          e[k*DW +: DW] = y[15:0];
        end
      end
      exp_q.push_back('{c + 3, e});
      m_phase = (m_phase + m_ratio) % (N * 256);
      last_launch = c;
    end
    cur_f[m_wptr] = d;
    if (m_wptr == N - 1) begin
      prev_f = cur_f;
      m_wptr = 0; m_phase = 0; m_ratio = rt; m_primed = 1;
      fs_q.push_back(c + 1);
    end else begin
      m_wptr++;
    end
  endtask

  // in_valid for one cycle, next send starts gap cycles later (gap >= 2)
  task automatic send(input logic [WW-1:0] d, input logic byp, input int gap);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; bypass = byp;
    model_step(cyc, d, byp, int'(ratio));
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (gap - 2) @(posedge clk);
  endtask

  function automatic int lg(input int idx, input int c);
    if (idx < dut_log.size()) return chv(dut_log[idx], c);
    return 32'h7fffffff;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("out_valid_unexpected", cyc, -1);
        else begin
          e = exp_q.pop_front();
          chk("out_valid_latency", cyc, e.due);
          chk("out_ch0", chv(out_data, 0), chv(e.word, 0));
          chk("out_ch1", chv(out_data, 1), chv(e.word, 1));
          dut_log.push_back(out_data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        chk("out_valid_present", out_valid, 1);
        void'(exp_q.pop_front());
      end
      if (frame_start) begin
        fs_count++;
        if (fs_q.size() == 0) chk("frame_start_unexpected", cyc, -1);
        else chk("frame_start_timing", cyc, fs_q.pop_front());
      end else if (fs_q.size() > 0 && fs_q[0] <= cyc) begin
        chk("frame_start_present", frame_start, 1);
        void'(fs_q.pop_front());
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int rt;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; bypass = 1'b0; ratio = 10'd256;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_frame_start", frame_start, 0);
    chk("reset_overrun", overrun, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // frame A: unprimed, outputs zero
    for (int k = 0; k < N; k++) send(mk(k, -k), 1'b0, 8);
    // frame B: ratio 1.0 replay of A; ratio moves to 2.0 mid-frame
    for (int k = 0; k < N; k++) begin
      if (k == 8) ratio = 10'd512;
      send(mk(k, -k), 1'b0, 8);
    end
    // frame C: plays B at 2.0; ratio moves to 0.5
    for (int k = 0; k < N; k++) begin
      if (k == 8) ratio = 10'd128;
      send(mk(16 * k, -16 * k), 1'b0, 8);
    end
    // frame D: plays C at 0.5
    for (int k = 0; k < N; k++) begin
      if (k == 8) ratio = 10'd256;
      send(mk(k, -k), 1'b0, 8);
    end
    repeat (6) @(posedge clk);

    for (int k = 0; k < N; k++) begin
      chk($sformatf("lit_A%0d_ch0", k), lg(k, 0), 0);
      chk($sformatf("lit_B%0d_ch0", k), lg(16 + k, 0), k);
      chk($sformatf("lit_B%0d_ch1", k), lg(16 + k, 1), -k);
      chk($sformatf("lit_C%0d_ch0", k), lg(32 + k, 0), (2 * k) % 16);
      chk($sformatf("lit_D%0d_ch0", k), lg(48 + k, 0), 8 * k);
      chk($sformatf("lit_D%0d_ch1", k), lg(48 + k, 1), -8 * k);
    end
    chk("frame_start_count_4", fs_count, 4);
    chk("overrun_clear", overrun, 0);

    // random frames with random ratio (incl. 0 and max) and bypass
    for (int f = 0; f < 4; f++) begin
      if (f == 0) rt = 0;
      else if (f == 1) rt = 1023;
      else rt = int'($urandom_range(0, 1023));
      for (int k = 0; k < N; k++) begin
        if (k == N - 1) ratio = RW'(rt);
        send($urandom, ($urandom_range(0, 3) == 0), int'($urandom_range(4, 9)));
      end
    end
    repeat (10) @(posedge clk);

    // overrun: two samples 2 cycles apart
    send($urandom, 1'b0, 2);
    send($urandom, 1'b0, 8);
    @(negedge clk);
    chk("overrun_set", overrun, 1);
    for (int k = 0; k < 6; k++) begin
      send($urandom, 1'b0, 8);
      @(negedge clk);
      chk("overrun_sticky", overrun, 1);
    end
    repeat (6) @(posedge clk);

    // asynchronous reset mid-frame
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_out_data", out_data, 0);
    chk("midreset_frame_start", frame_start, 0);
    chk("midreset_overrun", overrun, 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    ratio = 10'd256;

    // unprimed again, then a few replayed samples
    for (int k = 0; k < N + 4; k++) send(mk(k + 1, -(k + 1)), 1'b0, 8);
    repeat (8) @(posedge clk);
    chk("expect_queue_drained", exp_q.size(), 0);
    chk("frame_start_count_9", fs_count, 9);
    chk("post_reset_replay_ch0", lg(dut_log.size() - 1, 0), 4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
